// File: rtl/spi_slave_burst_ctrl.sv
// SPI slave protocol sequencer: decodes the command byte, walks the address/dummy/data phases,
// programs the pad shifter bit counters and issues one address-tagged word per data word.
module spi_slave_burst_ctrl #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int DUMMY_RESET = 32,
  parameter int CNT_W       = 8
) (
  input  logic                  sclk,
  input  logic                  sys_rst,
  input  logic                  cs,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_data_valid,
  input  logic                  tx_done,
  output logic [CNT_W-1:0]      rx_counter,
  output logic                  rx_counter_upd,
  output logic [CNT_W-1:0]      tx_counter,
  output logic                  tx_counter_upd,
  output logic [1:0]            lane_mode,
  output logic                  pad_dir_tx,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_data_valid,
  output logic [ADDR_WIDTH-1:0] ctrl_addr,
  output logic                  ctrl_addr_valid,
  output logic                  ctrl_rd_wr,
  output logic [DATA_WIDTH-1:0] ctrl_data_rx,
  output logic                  ctrl_data_rx_valid,
  input  logic [DATA_WIDTH-1:0] ctrl_data_tx,
  input  logic                  ctrl_data_tx_valid,
  output logic                  ctrl_data_tx_ready,
  output logic [15:0]           wrap_length,
  output logic                  tx_underrun,
  output logic [2:0]            state_dbg
);

  // Handshakes: every *_valid, *_upd and ctrl_data_tx_ready output is a single-cycle pulse with
  // its data registered on the same edge; rx_data_valid / tx_done are single-cycle qualifiers
  // and only the one matching the current phase is honoured.

  typedef enum logic [2:0] {
    IDLE_CMD = 3'd0,
    ADDR     = 3'd1,
    DUMMY    = 3'd2,
    DATA_RX  = 3'd3,
    DATA_TX  = 3'd4,
    ERROR    = 3'd5
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(DATA_WIDTH / 8);

  function automatic logic [CNT_W-1:0] lane_cnt(input int unsigned bits, input logic [1:0] lm);
    int unsigned v;
    case (lm)
      2'b01:   v = bits >> 1;
      2'b10:   v = bits >> 2;
      default: v = bits;
    endcase
    return CNT_W'(v - 1);
  endfunction

  state_t                state, state_n;
  logic                  reg_op, reg_op_n;
  logic [1:0]            reg_idx, reg_idx_n;
  logic [7:0]            dummy_reg, dummy_n;
  logic [1:0]            lane_n;
  logic [15:0]           wrap_n;
  logic [ADDR_WIDTH-1:0] start_addr, start_n, cur_addr, cur_n;
  logic [15:0]           word_cnt, wcnt_n;
  logic                  cs_q;

  logic [CNT_W-1:0]      rx_cnt_n, tx_cnt_n;
  logic                  rx_upd_n, tx_upd_n, tx_dv_n, addr_v_n, rx_v_n, ready_n;
  logic                  rd_wr_n, underrun_n, step, rd_issue;
  logic [DATA_WIDTH-1:0] tx_data_n, rx_word_n;
  logic [ADDR_WIDTH-1:0] addr_n;

  logic [ADDR_WIDTH-1:0] rx_addr, addr_sel, start_sel, addr_adv;
  logic [15:0]           cnt_inc, cnt_adv;
  logic                  wrap_hit;
  logic [7:0]            reg_rd_val;

  assign rx_addr   = ADDR_WIDTH'(rx_data);
  assign state_dbg = state;

  always_comb begin
    reg_rd_val = dummy_reg;
    case (rx_data[1:0])
      2'd1:    reg_rd_val = {6'b0, lane_mode};
      2'd2:    reg_rd_val = wrap_length[7:0];
      2'd3:    reg_rd_val = wrap_length[15:8];
      default: reg_rd_val = dummy_reg;
    endcase
  end

  // In ADDR the first word's address comes straight off rx_data (zero-dummy read path).
  always_comb begin
    addr_sel  = (state == ADDR) ? rx_addr : cur_addr;
    start_sel = (state == ADDR) ? rx_addr : start_addr;
    cnt_inc   = ((state == ADDR) ? 16'd0 : word_cnt) + 16'd1;
    wrap_hit  = (wrap_length != 16'd0) && (cnt_inc == wrap_length);
    addr_adv  = wrap_hit ? start_sel : addr_sel + ADDR_STEP;
    cnt_adv   = wrap_hit ? 16'd0 : cnt_inc;
  end

  always_comb begin
    state_n    = state;
    reg_op_n   = reg_op;
    reg_idx_n  = reg_idx;
    dummy_n    = dummy_reg;
    lane_n     = lane_mode;
    wrap_n     = wrap_length;
    start_n    = start_addr;
    cur_n      = cur_addr;
    wcnt_n     = word_cnt;
    rx_cnt_n   = rx_counter;
    tx_cnt_n   = tx_counter;
    rx_upd_n   = 1'b0;
    tx_upd_n   = 1'b0;
    tx_data_n  = tx_data;
    tx_dv_n    = 1'b0;
    addr_n     = ctrl_addr;
    addr_v_n   = 1'b0;
    rd_wr_n    = ctrl_rd_wr;
    rx_word_n  = ctrl_data_rx;
    rx_v_n     = 1'b0;
    ready_n    = 1'b0;
    underrun_n = tx_underrun;
    step       = 1'b0;
    rd_issue   = 1'b0;

    if (cs) begin
      state_n    = IDLE_CMD;
      reg_op_n   = 1'b0;
      rx_cnt_n   = lane_cnt(8, lane_mode);
      rx_upd_n   = !cs_q;
      underrun_n = 1'b0;
    end else begin
      case (state)
        IDLE_CMD: if (rx_data_valid) begin
          reg_idx_n = rx_data[1:0];
          if (rx_data[7:0] == 8'h02 || rx_data[7:0] == 8'h0B) begin
            state_n  = ADDR;
            reg_op_n = 1'b0;
            rd_wr_n  = (rx_data[7:0] == 8'h0B);
            rx_cnt_n = lane_cnt(ADDR_WIDTH, lane_mode);
            rx_upd_n = 1'b1;
          end else if (rx_data[7:2] == 6'b100000) begin
            state_n  = DATA_RX;
            reg_op_n = 1'b1;
            rx_cnt_n = lane_cnt(8, lane_mode);
            rx_upd_n = 1'b1;
          end else if (rx_data[7:2] == 6'b110000) begin
            state_n   = DATA_TX;
            reg_op_n  = 1'b1;
            tx_cnt_n  = lane_cnt(8, lane_mode);
            tx_upd_n  = 1'b1;
            tx_data_n = DATA_WIDTH'(reg_rd_val);
            tx_dv_n   = 1'b1;
          end else begin
            state_n = ERROR;
          end
        end
        ADDR: if (rx_data_valid) begin
          start_n = rx_addr;
          cur_n   = rx_addr;
          wcnt_n  = 16'd0;
          if (!ctrl_rd_wr) begin
            state_n  = DATA_RX;
            rx_cnt_n = lane_cnt(DATA_WIDTH, lane_mode);
            rx_upd_n = 1'b1;
          end else if (dummy_reg != 8'd0) begin
            state_n  = DUMMY;
            rx_cnt_n = CNT_W'(dummy_reg) - CNT_W'(1);
            rx_upd_n = 1'b1;
          end else begin
            state_n  = DATA_TX;
            rd_issue = 1'b1;
          end
        end
        DUMMY: if (rx_data_valid) begin
          state_n  = DATA_TX;
          rd_issue = 1'b1;
        end
        DATA_RX: if (rx_data_valid) begin
          if (reg_op) begin
            case (reg_idx)
              2'd0:    dummy_n = rx_data[7:0];
              2'd1:    lane_n  = (rx_data[1:0] == 2'b11) ? 2'b00 : rx_data[1:0];
              2'd2:    wrap_n  = {wrap_length[15:8], rx_data[7:0]};
              default: wrap_n  = {rx_data[7:0], wrap_length[7:0]};
            endcase
            state_n  = IDLE_CMD;
            reg_op_n = 1'b0;
            // The next command already shifts in with the freshly written lane mode.
            rx_cnt_n = lane_cnt(8, lane_n);
            rx_upd_n = 1'b1;
          end else begin
            rx_word_n = rx_data;
            rx_v_n    = 1'b1;
            step      = 1'b1;
            rx_cnt_n  = lane_cnt(DATA_WIDTH, lane_mode);
            rx_upd_n  = 1'b1;
          end
        end
        DATA_TX: if (tx_done) begin
          if (reg_op) begin
            state_n  = IDLE_CMD;
            reg_op_n = 1'b0;
            rx_cnt_n = lane_cnt(8, lane_mode);
            rx_upd_n = 1'b1;
          end else begin
            rd_issue = 1'b1;
          end
        end
        ERROR: state_n = ERROR;
        default: state_n = ERROR;
      endcase

      if (rd_issue) begin
        step     = 1'b1;
        tx_cnt_n = lane_cnt(DATA_WIDTH, lane_mode);
        tx_upd_n = 1'b1;
        tx_dv_n  = 1'b1;
        if (ctrl_data_tx_valid) begin
          tx_data_n = ctrl_data_tx;
          ready_n   = 1'b1;
        end else begin
          tx_data_n  = '1;
          underrun_n = 1'b1;
        end
      end

      if (step) begin
        addr_n   = addr_sel;
        addr_v_n = 1'b1;
        cur_n    = addr_adv;
        wcnt_n   = cnt_adv;
      end
    end
  end

  always_ff @(posedge sclk) begin
    if (sys_rst) begin
      state              <= IDLE_CMD;
      reg_op             <= 1'b0;
      reg_idx            <= 2'd0;
      dummy_reg          <= 8'(DUMMY_RESET);
      lane_mode          <= 2'b00;
      wrap_length        <= 16'd0;
      start_addr         <= '0;
      cur_addr           <= '0;
      word_cnt           <= 16'd0;
      cs_q               <= 1'b1;
      rx_counter         <= lane_cnt(8, 2'b00);
      rx_counter_upd     <= 1'b1;
      tx_counter         <= '0;
      tx_counter_upd     <= 1'b0;
      pad_dir_tx         <= 1'b0;
      tx_data            <= '0;
      tx_data_valid      <= 1'b0;
      ctrl_addr          <= '0;
      ctrl_addr_valid    <= 1'b0;
      ctrl_rd_wr         <= 1'b0;
      ctrl_data_rx       <= '0;
      ctrl_data_rx_valid <= 1'b0;
      ctrl_data_tx_ready <= 1'b0;
      tx_underrun        <= 1'b0;
    end else begin
      state              <= state_n;
      reg_op             <= reg_op_n;
      reg_idx            <= reg_idx_n;
      dummy_reg          <= dummy_n;
      lane_mode          <= lane_n;
      wrap_length        <= wrap_n;
      start_addr         <= start_n;
      cur_addr           <= cur_n;
      word_cnt           <= wcnt_n;
      cs_q               <= cs;
      rx_counter         <= rx_cnt_n;
      rx_counter_upd     <= rx_upd_n;
      tx_counter         <= tx_cnt_n;
      tx_counter_upd     <= tx_upd_n;
      pad_dir_tx         <= (state_n == DATA_TX);
      tx_data            <= tx_data_n;
      tx_data_valid      <= tx_dv_n;
      ctrl_addr          <= addr_n;
      ctrl_addr_valid    <= addr_v_n;
      ctrl_rd_wr         <= rd_wr_n;
      ctrl_data_rx       <= rx_word_n;
      ctrl_data_rx_valid <= rx_v_n;
      ctrl_data_tx_ready <= ready_n;
      tx_underrun        <= underrun_n;
    end
  end

endmodule
